// File: rtl/datacache_wb_param_if.sv
// Bus interfaces for the write-back data cache: CPU request side and block-memory side.
// The CPU interface is mastered by the CPU; the memory interface is mastered by the cache.

interface datacache_wb_param_cpu_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic              rd_en;
  logic              wr_en;
  logic              flush;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              over;
  logic              busy;

  modport master (
    output addr, rd_en, wr_en, flush, wdata,
    input  rdata, over, busy
  );

  modport slave (
    input  addr, rd_en, wr_en, flush, wdata,
    output rdata, over, busy
  );
endinterface

interface datacache_wb_param_mem_if #(
  parameter int ADDR_W = 32,
  parameter int BLK_W  = 256
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [BLK_W-1:0]  mem_wdata;
  logic [BLK_W-1:0]  mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/datacache_wb_param.sv
// Direct-mapped, write-back, write-allocate data cache with a ready-handshaked block
// memory port and a whole-cache flush that writes back every dirty line.

module datacache_wb_param #(
  parameter int ADDR_W         = 32,
  parameter int WORD_W         = 32,
  parameter int LINES          = 4,
  parameter int WORDS_PER_LINE = 8
) (
  input logic                       clk,
  input logic                       rst,
  datacache_wb_param_cpu_if.slave   cpu,
  datacache_wb_param_mem_if.master  mem
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int WOFF_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = WOFF_W + 2;
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int BLK_W  = WORD_W * WORDS_PER_LINE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WBACK,
    S_REFILL,
    S_DONE,
    S_FLUSH_SCAN,
    S_FLUSH_WB
  } state_t;

  state_t            state_q;
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [BLK_W-1:0]  data_mem [LINES];

  logic              is_wr_q;
  logic [TAG_W-1:0]  lat_tag_q;
  logic [IDX_W-1:0]  lat_idx_q;
  logic [WOFF_W-1:0] lat_off_q;
  logic [WORD_W-1:0] lat_wdata_q;
  logic [IDX_W-1:0]  scan_q;
  logic [BLK_W-1:0]  line_q;

  logic [WORD_W-1:0] rdata_q;
  logic              over_q;
  logic              busy_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [TAG_W-1:0]  in_tag;
  logic [IDX_W-1:0]  in_idx;
  logic [WOFF_W-1:0] in_off;
  logic              addr_lsb_unused;
  logic              hit;
  logic [WORD_W-1:0] hit_word;
  logic [BLK_W-1:0]  merged_line;
  logic              refill_done;
  logic              arr_we;
  logic [BLK_W-1:0]  arr_wline;
  logic              arr_re;
  logic [IDX_W-1:0]  arr_ridx;

  assign in_tag          = cpu.addr[ADDR_W-1 -: TAG_W];
  assign in_idx          = cpu.addr[OFF_W +: IDX_W];
  assign in_off          = cpu.addr[2 +: WOFF_W];
  assign addr_lsb_unused = ^cpu.addr[1:0];

  assign hit         = valid_q[lat_idx_q] && (tag_mem[lat_idx_q] == lat_tag_q);
  assign hit_word    = line_q[WORD_W*lat_off_q +: WORD_W];
  assign refill_done = (state_q == S_REFILL) && mem_rd_q && mem.mem_ready;

  // Store path: the addressed word takes the latched write data, the rest keep the line.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_merge
      assign merged_line[gi*WORD_W +: WORD_W] =
        (lat_off_q == WOFF_W'(gi)) ? lat_wdata_q : line_q[gi*WORD_W +: WORD_W];
    end
  endgenerate

  always_comb begin
    arr_we    = 1'b0;
    arr_wline = merged_line;
    case (state_q)
      S_LOOKUP: arr_we = hit && is_wr_q;
      S_REFILL: begin
        arr_we    = refill_done;
        arr_wline = mem.mem_rdata;
      end
      S_DONE:   arr_we = is_wr_q;
      default:  arr_we = 1'b0;
    endcase
    if (rst) begin
      arr_we = 1'b0;
    end
  end

  // The data array is read one cycle ahead: while idle for the incoming index, while scanning for the scan index.
  assign arr_re   = (state_q == S_IDLE) || (state_q == S_FLUSH_SCAN);
  assign arr_ridx = (state_q == S_FLUSH_SCAN) ? scan_q : in_idx;

  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_mem[lat_idx_q]  <= lat_tag_q;
      data_mem[lat_idx_q] <= arr_wline;
    end
    if (refill_done) begin
      line_q <= mem.mem_rdata;
    end else if (arr_re) begin
      line_q <= data_mem[arr_ridx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      rdata_q    <= '0;
      over_q     <= 1'b0;
      busy_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      over_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu.flush) begin
            scan_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_FLUSH_SCAN;
          end else if (cpu.wr_en || cpu.rd_en) begin
            is_wr_q     <= cpu.wr_en;
            lat_tag_q   <= in_tag;
            lat_idx_q   <= in_idx;
            lat_off_q   <= in_off;
            lat_wdata_q <= cpu.wdata;
            busy_q      <= 1'b1;
            state_q     <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (hit) begin
            if (is_wr_q) begin
              dirty_q[lat_idx_q] <= 1'b1;
              rdata_q            <= lat_wdata_q;
            end else begin
              rdata_q <= hit_word;
            end
            over_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (valid_q[lat_idx_q] && dirty_q[lat_idx_q]) begin
            // Victim address is rebuilt from the stored tag, not the requesting one.
            mem_wr_q   <= 1'b1;
            mem_addr_q <= {tag_mem[lat_idx_q], lat_idx_q, OFF_W'(0)};
            state_q    <= S_WBACK;
          end else begin
            valid_q[lat_idx_q] <= 1'b0;
            mem_rd_q           <= 1'b1;
            mem_addr_q         <= {lat_tag_q, lat_idx_q, OFF_W'(0)};
            state_q            <= S_REFILL;
          end
        end

        S_WBACK: begin
          if (mem.mem_ready) begin
            mem_wr_q           <= 1'b0;
            valid_q[lat_idx_q] <= 1'b0;
            dirty_q[lat_idx_q] <= 1'b0;
            mem_rd_q           <= 1'b1;
            mem_addr_q         <= {lat_tag_q, lat_idx_q, OFF_W'(0)};
            state_q            <= S_REFILL;
          end
        end

        S_REFILL: begin
          if (refill_done) begin
            mem_rd_q           <= 1'b0;
            valid_q[lat_idx_q] <= 1'b1;
            dirty_q[lat_idx_q] <= 1'b0;
            state_q            <= S_DONE;
          end
        end

        S_DONE: begin
          if (is_wr_q) begin
            dirty_q[lat_idx_q] <= 1'b1;
            rdata_q            <= lat_wdata_q;
          end else begin
            rdata_q <= hit_word;
          end
          over_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        S_FLUSH_SCAN: begin
          if (valid_q[scan_q] && dirty_q[scan_q]) begin
            mem_wr_q   <= 1'b1;
            mem_addr_q <= {tag_mem[scan_q], scan_q, OFF_W'(0)};
            state_q    <= S_FLUSH_WB;
          end else if (scan_q == IDX_W'(LINES - 1)) begin
            over_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            scan_q <= scan_q + 1'b1;
          end
        end

        S_FLUSH_WB: begin
          // Returning to the scan with the same index lets the now-clean line advance it.
          if (mem.mem_ready) begin
            mem_wr_q        <= 1'b0;
            dirty_q[scan_q] <= 1'b0;
            state_q         <= S_FLUSH_SCAN;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu.rdata     = rdata_q;
  assign cpu.over      = over_q;
  assign cpu.busy      = busy_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_rd    = mem_rd_q;
  assign mem.mem_wr    = mem_wr_q;
  assign mem.mem_wdata = mem_wr_q ? line_q : '0;

endmodule

// File: tb/tb_datacache_wb_param.sv
// Directed bench for datacache_wb_param (4 lines x 8 words); block memory returns word k of block B as B+k
// and raises mem_ready on the third cycle of each strobe.

module tb_datacache_wb_param;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int LINES  = 4;
  localparam int WPL    = 8;
  localparam int BLK_W  = WORD_W * WPL;

  logic clk;
  logic rst;

  datacache_wb_param_cpu_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) cpu_bus ();
  datacache_wb_param_mem_if #(.ADDR_W(ADDR_W), .BLK_W(BLK_W))   mem_bus ();

  datacache_wb_param #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINES(LINES), .WORDS_PER_LINE(WPL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu(cpu_bus),
    .mem(mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit               log_wr   [$];
  logic [31:0]      log_addr [$];
  logic [BLK_W-1:0] log_data [$];
  int               mem_cnt  = 0;
  int               both_high = 0;

  // Memory model: completes each strobe on its third cycle and logs the transfer.
  always @(negedge clk) begin
    logic [BLK_W-1:0] blk;
    if (mem_bus.mem_rd && mem_bus.mem_wr) both_high++;
    if (mem_bus.mem_ready) begin
      mem_bus.mem_ready = 1'b0;
      mem_cnt = 0;
    end else if (mem_bus.mem_rd || mem_bus.mem_wr) begin
      mem_cnt++;
      if (mem_cnt == 3) begin
        for (int k = 0; k < WPL; k++) blk[WORD_W*k +: WORD_W] = mem_bus.mem_addr + k;
        mem_bus.mem_rdata = blk;
        mem_bus.mem_ready = 1'b1;
        log_wr.push_back(mem_bus.mem_wr);
        log_addr.push_back(mem_bus.mem_addr);
        log_data.push_back(mem_bus.mem_wdata);
      end
    end else begin
      mem_cnt = 0;
    end
  end

  task automatic clear_log();
    log_wr.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  // Drives one request and holds it until over; lat counts posedges from the accepting edge to the over edge.
  task automatic do_op(input logic op_rd, input logic op_wr, input logic op_fl,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output int strobes);
    lat = 0;
    strobes = 0;
    @(negedge clk);
    cpu_bus.addr  = a;
    cpu_bus.wdata = wd;
    cpu_bus.rd_en = op_rd;
    cpu_bus.wr_en = op_wr;
    cpu_bus.flush = op_fl;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (mem_bus.mem_rd || mem_bus.mem_wr) strobes++;
    end while (!cpu_bus.over && lat < 300);
    rd = cpu_bus.rdata;
    cpu_bus.rd_en = 1'b0;
    cpu_bus.wr_en = 1'b0;
    cpu_bus.flush = 1'b0;
    n_cmp++;
    if (cpu_bus.over !== 1'b1) begin
      n_bad++;
      $display("FAIL op_timeout addr=%h: over=%b after %0d cycles, required 1", a, cpu_bus.over, lat);
    end
    $display("op rd=%b wr=%b fl=%b addr=%h wdata=%h -> rdata=%h lat=%0d strobe_cycles=%0d mem_xfers=%0d",
             op_rd, op_wr, op_fl, a, wd, rd, lat, strobes, log_addr.size());
  endtask

  task automatic test_reset();
    cpu_bus.addr = '0; cpu_bus.wdata = '0;
    cpu_bus.rd_en = 0; cpu_bus.wr_en = 0; cpu_bus.flush = 0;
    mem_bus.mem_ready = 0; mem_bus.mem_rdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cpu_bus.over !== 1'b0) begin n_bad++; $display("FAIL reset_over: got %b want 0", cpu_bus.over); end
    n_cmp++; if (cpu_bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", cpu_bus.busy); end
    n_cmp++; if (cpu_bus.rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", cpu_bus.rdata); end
    n_cmp++; if ({mem_bus.mem_rd, mem_bus.mem_wr} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b want 00", {mem_bus.mem_rd, mem_bus.mem_wr}); end
    n_cmp++; if (mem_bus.mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_bus.mem_addr); end
    n_cmp++; if (mem_bus.mem_wdata !== '0) begin n_bad++; $display("FAIL reset_mem_wdata: got nonzero want 0"); end
    @(negedge clk);
    rst = 1'b0;
    $display("op reset released");
  endtask

  task automatic test_read_miss_then_hit();
    int lat, stb; logic [31:0] rd;
    clear_log();
    do_op(1, 0, 0, 32'h40, 32'h0, lat, rd, stb);
    n_cmp++; if (log_addr.size() != 1) begin n_bad++; $display("FAIL miss40_xfers: got %0d want 1", log_addr.size()); end
    else begin
      n_cmp++; if (log_wr[0] !== 1'b0 || log_addr[0] !== 32'h40) begin n_bad++; $display("FAIL miss40_rd: got wr=%b addr=%h want rd at 40", log_wr[0], log_addr[0]); end
    end
    n_cmp++; if (rd !== 32'h40) begin n_bad++; $display("FAIL miss40_rdata: got %h want 00000040", rd); end
    clear_log();
    do_op(1, 0, 0, 32'h44, 32'h0, lat, rd, stb);
    n_cmp++; if (rd !== 32'h41) begin n_bad++; $display("FAIL hit44_rdata: got %h want 00000041", rd); end
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL hit44_latency: got %0d want 2", lat); end
    n_cmp++; if (stb != 0) begin n_bad++; $display("FAIL hit44_strobes: got %0d want 0", stb); end
  endtask

  task automatic test_write_hit();
    int lat, stb; logic [31:0] rd;
    clear_log();
    do_op(0, 1, 0, 32'h48, 32'hDEADBEEF, lat, rd, stb);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL whit48_latency: got %0d want 2", lat); end
    n_cmp++; if (stb != 0) begin n_bad++; $display("FAIL whit48_strobes: got %0d want 0", stb); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL whit48_rdata: got %h want deadbeef", rd); end
    do_op(1, 0, 0, 32'h48, 32'h0, lat, rd, stb);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd48_rdata: got %h want deadbeef", rd); end
  endtask

  task automatic test_victim_writeback();
    int lat, stb; logic [31:0] rd; logic [BLK_W-1:0] blk; logic [31:0] w0, w2;
    clear_log();
    do_op(1, 0, 0, 32'hC0, 32'h0, lat, rd, stb);
    n_cmp++; if (log_addr.size() != 2) begin n_bad++; $display("FAIL wb_xfers: got %0d want 2", log_addr.size()); end
    else begin
      blk = log_data[0];
      w0 = blk[31:0];
      w2 = blk[95:64];
      n_cmp++; if (log_wr[0] !== 1'b1 || log_addr[0] !== 32'h40) begin n_bad++; $display("FAIL wb_first: got wr=%b addr=%h want wr at 40", log_wr[0], log_addr[0]); end
      n_cmp++; if (w2 !== 32'hDEADBEEF || w0 !== 32'h40) begin n_bad++; $display("FAIL wb_data: got w0=%h w2=%h want 00000040 deadbeef", w0, w2); end
      n_cmp++; if (log_wr[1] !== 1'b0 || log_addr[1] !== 32'hC0) begin n_bad++; $display("FAIL wb_refill: got wr=%b addr=%h want rd at c0", log_wr[1], log_addr[1]); end
    end
    n_cmp++; if (rd !== 32'hC0) begin n_bad++; $display("FAIL wb_rdata: got %h want 000000c0", rd); end
  endtask

  task automatic test_write_miss();
    int lat, stb; logic [31:0] rd;
    clear_log();
    do_op(0, 1, 0, 32'h104, 32'h12345678, lat, rd, stb);
    n_cmp++; if (log_addr.size() != 1) begin n_bad++; $display("FAIL wmiss_xfers: got %0d want 1", log_addr.size()); end
    else begin
      n_cmp++; if (log_wr[0] !== 1'b0 || log_addr[0] !== 32'h100) begin n_bad++; $display("FAIL wmiss_rd: got wr=%b addr=%h want rd at 100", log_wr[0], log_addr[0]); end
    end
    clear_log();
    do_op(1, 0, 0, 32'h104, 32'h0, lat, rd, stb);
    n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL wmiss_readback: got %h want 12345678", rd); end
    n_cmp++; if (stb != 0) begin n_bad++; $display("FAIL wmiss_readback_strobes: got %0d want 0", stb); end
  endtask

  task automatic test_flush();
    int lat, stb, extra; logic [31:0] rd; logic [BLK_W-1:0] blk; logic [31:0] w;
    do_op(0, 1, 0, 32'h60, 32'hCAFE0003, lat, rd, stb);
    clear_log();
    do_op(1, 0, 1, 32'h48, 32'h0, lat, rd, stb);
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (cpu_bus.over) extra++;
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL flush_over_count: got %0d extra pulses want 0", extra); end
    n_cmp++; if (log_addr.size() != 2) begin n_bad++; $display("FAIL flush_xfers: got %0d want 2", log_addr.size()); end
    else begin
      n_cmp++; if (log_wr[0] !== 1'b1 || log_addr[0] !== 32'h100) begin n_bad++; $display("FAIL flush_line0: got wr=%b addr=%h want wr at 100", log_wr[0], log_addr[0]); end
      blk = log_data[0]; w = blk[63:32];
      n_cmp++; if (w !== 32'h12345678) begin n_bad++; $display("FAIL flush_line0_data: got %h want 12345678", w); end
      n_cmp++; if (log_wr[1] !== 1'b1 || log_addr[1] !== 32'h60) begin n_bad++; $display("FAIL flush_line3: got wr=%b addr=%h want wr at 60", log_wr[1], log_addr[1]); end
      blk = log_data[1]; w = blk[31:0];
      n_cmp++; if (w !== 32'hCAFE0003) begin n_bad++; $display("FAIL flush_line3_data: got %h want cafe0003", w); end
    end
    clear_log();
    do_op(1, 0, 0, 32'h180, 32'h0, lat, rd, stb);
    do_op(1, 0, 0, 32'hE0, 32'h0, lat, rd, stb);
    n_cmp++; if (log_addr.size() != 2) begin n_bad++; $display("FAIL postflush_xfers: got %0d want 2", log_addr.size()); end
    else begin
      n_cmp++; if ({log_wr[0], log_wr[1]} !== 2'b00) begin n_bad++; $display("FAIL postflush_no_wr: got wr flags %b%b want 00", log_wr[0], log_wr[1]); end
      n_cmp++; if (log_addr[0] !== 32'h180 || log_addr[1] !== 32'hE0) begin n_bad++; $display("FAIL postflush_addr: got %h %h want 180 e0", log_addr[0], log_addr[1]); end
    end
    n_cmp++; if (rd !== 32'hE0) begin n_bad++; $display("FAIL postflush_rdata: got %h want 000000e0", rd); end
  endtask

  task automatic test_reset_mid_refill();
    int lat, stb, waited, overs; logic [31:0] rd;
    clear_log();
    @(negedge clk);
    cpu_bus.addr = 32'h200;
    cpu_bus.rd_en = 1'b1;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!mem_bus.mem_rd && waited < 50);
    n_cmp++; if (mem_bus.mem_rd !== 1'b1) begin n_bad++; $display("FAIL midrst_refill_start: got mem_rd=%b want 1", mem_bus.mem_rd); end
    @(negedge clk);
    rst = 1'b1;
    cpu_bus.rd_en = 1'b0;
    @(posedge clk); #1;
    overs = cpu_bus.over ? 1 : 0;
    n_cmp++; if (mem_bus.mem_rd !== 1'b0) begin n_bad++; $display("FAIL midrst_mem_rd: got %b want 0", mem_bus.mem_rd); end
    n_cmp++; if (cpu_bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", cpu_bus.busy); end
    n_cmp++; if (cpu_bus.rdata !== 32'h0) begin n_bad++; $display("FAIL midrst_rdata: got %h want 0", cpu_bus.rdata); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (cpu_bus.over) overs++;
    end
    n_cmp++; if (overs != 0) begin n_bad++; $display("FAIL midrst_over: got %0d pulses want 0", overs); end
    $display("op reset during refill of 200");
    clear_log();
    do_op(1, 0, 0, 32'h200, 32'h0, lat, rd, stb);
    n_cmp++; if (log_addr.size() != 1) begin n_bad++; $display("FAIL midrst_remiss: got %0d xfers want 1", log_addr.size()); end
    else begin
      n_cmp++; if (log_wr[0] !== 1'b0 || log_addr[0] !== 32'h200) begin n_bad++; $display("FAIL midrst_remiss_addr: got wr=%b addr=%h want rd at 200", log_wr[0], log_addr[0]); end
    end
    n_cmp++; if (rd !== 32'h200) begin n_bad++; $display("FAIL midrst_rdata_after: got %h want 00000200", rd); end
  endtask

  initial begin
    test_reset();
    test_read_miss_then_hit();
    test_write_hit();
    test_victim_writeback();
    test_write_miss();
    test_flush();
    test_reset_mid_refill();
    n_cmp++;
    if (both_high != 0) begin n_bad++; $display("FAIL strobe_exclusive: got %0d cycles with both strobes want 0", both_high); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
